// File: rtl/key_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner_if
// Description : Key bus between the board key pins and the IO key peripheral.
//               Carries the raw pin levels in, and the debounced level plus
//               press/release/repeat event pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] Raw_Keys;
    logic [NUM_KEYS-1:0] Keys;
    logic [NUM_KEYS-1:0] Key_Held;
    logic [NUM_KEYS-1:0] Key_Pressed;
    logic [NUM_KEYS-1:0] Key_Released;
    logic [NUM_KEYS-1:0] Key_Repeat;

    // Pin side: supplies raw levels, observes conditioned results
    modport master (
        output Raw_Keys,
        input  Keys, Key_Held, Key_Pressed, Key_Released, Key_Repeat
    );

    // Conditioner side
    modport slave (
        input  Raw_Keys,
        output Keys, Key_Held, Key_Pressed, Key_Released, Key_Repeat
    );
endinterface
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner
// Description : Per-key two-flop synchronizer, shared tick prescaler and
//               debounce/auto-repeat FSM. Presents clean key levels with the
//               raw pin polarity plus single-cycle press/release/repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner #(
    parameter int NUM_KEYS            = 4,
    parameter bit KEY_ACTIVE_LOW      = 1'b1,
    parameter int TICK_CYCLES         = 50000,
    parameter int DEBOUNCE_TICKS      = 10,
    parameter int REPEAT_DELAY_TICKS  = 500,
    parameter int REPEAT_PERIOD_TICKS = 100
) (
    input  logic             IO_Clock,
    input  logic             IO_Reset,
    key_conditioner_if.slave keyBus
);

    localparam int c_tickWidth = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_dcWidth   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int c_rcMax     = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                                 REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
    localparam int c_rcWidth   = $clog2(c_rcMax + 1);

    localparam logic [c_tickWidth-1:0] c_tickLast   = c_tickWidth'(TICK_CYCLES - 1);
    localparam logic [c_dcWidth-1:0]   c_dcLast     = c_dcWidth'(DEBOUNCE_TICKS - 1);
    localparam logic [c_rcWidth-1:0]   c_delayLast  = c_rcWidth'(REPEAT_DELAY_TICKS - 1);
    localparam logic [c_rcWidth-1:0]   c_periodLast = c_rcWidth'(REPEAT_PERIOD_TICKS - 1);
    localparam bit                     c_repeatEn   = (REPEAT_DELAY_TICKS != 0);
    localparam logic [NUM_KEYS-1:0]    c_released   = {NUM_KEYS{KEY_ACTIVE_LOW}};

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] S_HELD         = 3'd2;
    localparam logic [2:0] S_REPEAT       = 3'd3;
    localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

    logic [NUM_KEYS-1:0]    r_sync1;
    logic [NUM_KEYS-1:0]    r_sync2;
    logic [c_tickWidth-1:0] r_tickCnt;
    logic [2:0]             r_state [NUM_KEYS];
    logic [c_dcWidth-1:0]   r_dc    [NUM_KEYS];
    logic [c_rcWidth-1:0]   r_rc    [NUM_KEYS];
    logic [NUM_KEYS-1:0]    r_fromRepeat;
    logic [NUM_KEYS-1:0]    r_held;
    logic [NUM_KEYS-1:0]    r_keys;
    logic [NUM_KEYS-1:0]    r_pressed;
    logic [NUM_KEYS-1:0]    r_released;
    logic [NUM_KEYS-1:0]    r_repeat;

    logic [NUM_KEYS-1:0]    w_p;
    logic                   w_tick;

    // Two-flop synchronizer; resets to the released pin level so no false press
    always_ff @(posedge IO_Clock) begin
        if (IO_Reset) begin
            r_sync1 <= c_released;
            r_sync2 <= c_released;
        end else begin
            r_sync1 <= keyBus.Raw_Keys;
            r_sync2 <= r_sync1;
        end
    end

    // p is 1 while the synchronized pin reads pressed, regardless of polarity
    assign w_p    = KEY_ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign w_tick = (r_tickCnt == c_tickLast);

    // Shared sample-tick prescaler, wraps after TICK_CYCLES cycles
    always_ff @(posedge IO_Clock) begin
        if (IO_Reset || w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    // Per-key debounce/repeat FSM; levels and pulses registered together so
    // every pulse lines up with the level change it reports
    always_ff @(posedge IO_Clock) begin
        if (IO_Reset) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_state[k] <= S_IDLE;
                r_dc[k]    <= '0;
                r_rc[k]    <= '0;
            end
            r_fromRepeat <= '0;
            r_held       <= '0;
            r_keys       <= c_released;
            r_pressed    <= '0;
            r_released   <= '0;
            r_repeat     <= '0;
        end else begin
            r_pressed  <= '0;
            r_released <= '0;
            r_repeat   <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                case (r_state[k])
                    S_IDLE: begin
                        // The tick in the entry cycle is deliberately not counted
                        if (w_p[k]) begin
                            r_state[k] <= S_PRESS_WAIT;
                            r_dc[k]    <= '0;
                        end
                    end
                    S_PRESS_WAIT: begin
                        if (!w_p[k]) begin
                            r_state[k] <= S_IDLE;
                        end else if (w_tick) begin
                            if (r_dc[k] == c_dcLast) begin
                                r_state[k]   <= S_HELD;
                                r_rc[k]      <= '0;
                                r_pressed[k] <= 1'b1;
                                r_held[k]    <= 1'b1;
                                r_keys[k]    <= ~KEY_ACTIVE_LOW;
                            end else begin
                                r_dc[k] <= r_dc[k] + 1'b1;
                            end
                        end
                    end
                    S_HELD, S_REPEAT: begin
                        // Leaving for release-wait freezes rc so a short glitch
                        // does not disturb the repeat cadence
                        if (!w_p[k]) begin
                            r_state[k]      <= S_RELEASE_WAIT;
                            r_dc[k]         <= '0;
                            r_fromRepeat[k] <= (r_state[k] == S_REPEAT);
                        end else if (w_tick && c_repeatEn) begin
                            if (r_rc[k] == ((r_state[k] == S_REPEAT) ? c_periodLast : c_delayLast)) begin
                                r_state[k]  <= S_REPEAT;
                                r_rc[k]     <= '0;
                                r_repeat[k] <= 1'b1;
                            end else begin
                                r_rc[k] <= r_rc[k] + 1'b1;
                            end
                        end
                    end
                    S_RELEASE_WAIT: begin
                        if (w_p[k]) begin
                            r_state[k] <= r_fromRepeat[k] ? S_REPEAT : S_HELD;
                        end else if (w_tick) begin
                            if (r_dc[k] == c_dcLast) begin
                                r_state[k]    <= S_IDLE;
                                r_released[k] <= 1'b1;
                                r_held[k]     <= 1'b0;
                                r_keys[k]     <= KEY_ACTIVE_LOW;
                            end else begin
                                r_dc[k] <= r_dc[k] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state[k] <= S_IDLE;
                        r_dc[k]    <= '0;
                        r_rc[k]    <= '0;
                        r_held[k]  <= 1'b0;
                        r_keys[k]  <= KEY_ACTIVE_LOW;
                    end
                endcase
            end
        end
    end

    assign keyBus.Keys         = r_keys;
    assign keyBus.Key_Held     = r_held;
    assign keyBus.Key_Pressed  = r_pressed;
    assign keyBus.Key_Released = r_released;
    assign keyBus.Key_Repeat   = r_repeat;

endmodule
`default_nettype wire
